// File: rtl/lfsr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_sched
//  Description : Round-robin scheduler sharing one Galois LFSR between NREQ
//                requesters, with seed load, warm-up stepping and reseed.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_sched #(
    parameter int              NREQ   = 4,
    parameter int              LEN    = 8,
    parameter logic [LEN-1:0]  TAPS   = 8'b10111000,
    parameter int              WARMUP = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LEN-1:0]  seed,
    input  logic            reseed,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [LEN-1:0]  rnd,
    output logic            busy
);

    localparam int            CW        = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int            PW        = $clog2(NREQ);
    localparam bit            HAS_WARM  = (WARMUP > 0);
    localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WARM  = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LEN-1:0]    sreg_q,  sreg_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [PW-1:0]     ptr_q,   ptr_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [LEN-1:0]    rnd_q,   rnd_d;

    logic              win_vld;
    logic [PW-1:0]     win_idx;

    // One Galois step: shift right, fold the tap mask in when bit 0 falls out.
    function automatic logic [LEN-1:0] lfsr_step(input logic [LEN-1:0] s);
        return {1'b0, s[LEN-1:1]} ^ (s[0] ? TAPS : '0);
    endfunction

    // Round-robin pick: scan upward from the slot after the last winner, with wrap.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(idx);
            end
        end
    end

    // Next-state logic for sequencing, arbitration and the LFSR itself.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        rnd_d   = rnd_q;
        case (state_q)
            S_LOAD: begin
                cnt_d = '0;
                // A zero seed would lock the LFSR, so it selects all-ones instead.
                sreg_d = (seed != '0) ? seed : '1;
                if (reseed)
                    state_d = S_LOAD;
                else
                    state_d = HAS_WARM ? S_WARM : S_SERVE;
            end
            S_WARM: begin
                if (reseed) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    sreg_d = lfsr_step(sreg_q);
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == WARM_LAST)
                        state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                // Reseed wins over any request at the same edge; pointer is kept.
                if (reseed) begin
                    state_d = S_LOAD;
                end else if (win_vld) begin
                    gnt_d[win_idx] = 1'b1;
                    rnd_d          = sreg_q;
                    sreg_d         = lfsr_step(sreg_q);
                    ptr_d          = win_idx;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State and output registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            sreg_q  <= '1;
            cnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            gnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
        end
    end

    assign gnt  = gnt_q;
    assign rnd  = rnd_q;
    assign busy = (state_q != S_SERVE);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_sched
//  Description : Directed-vector bench for lfsr_sched (WARMUP=0 and WARMUP=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_sched;

    logic       clk;
    logic       rst_n;
    logic [7:0] seed;
    logic       reseed;
    logic [3:0] req0, req4;
    logic [3:0] gnt0, gnt4;
    logic [7:0] rnd0, rnd4;
    logic       busy0, busy4;

    int n_vec;
    int n_bad;

    lfsr_sched #(.NREQ(4), .LEN(8), .TAPS(8'hB8), .WARMUP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .seed(seed), .reseed(reseed),
        .req(req0), .gnt(gnt0), .rnd(rnd0), .busy(busy0)
    );

    lfsr_sched #(.NREQ(4), .LEN(8), .TAPS(8'hB8), .WARMUP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .seed(seed), .reseed(reseed),
        .req(req4), .gnt(gnt4), .rnd(rnd4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic       rs;
        logic [7:0] seed;
        logic [3:0] gnt;
        logic [7:0] rnd;
        logic       chk_rnd;
        logic       busy;
    } vec_t;

    vec_t vt[22];

    logic [3:0] e0_gnt[6];
    logic [7:0] e0_rnd[6];

    initial begin
        // Table for the WARMUP=0 instance, starting in SERVE with sreg=01, pointer=3.
        vt[0]  = '{4'b0001, 1'b0, 8'h01, 4'b0001, 8'h01, 1'b1, 1'b0};
        vt[1]  = '{4'b0001, 1'b0, 8'h01, 4'b0001, 8'hB8, 1'b1, 1'b0};
        vt[2]  = '{4'b0001, 1'b0, 8'h01, 4'b0001, 8'h5C, 1'b1, 1'b0};
        vt[3]  = '{4'b0000, 1'b0, 8'h01, 4'b0000, 8'h00, 1'b0, 1'b0};
        vt[4]  = '{4'b1111, 1'b0, 8'h01, 4'b0010, 8'h2E, 1'b1, 1'b0};
        vt[5]  = '{4'b1111, 1'b0, 8'h01, 4'b0100, 8'h17, 1'b1, 1'b0};
        vt[6]  = '{4'b1111, 1'b0, 8'h01, 4'b1000, 8'hB3, 1'b1, 1'b0};
        vt[7]  = '{4'b1111, 1'b0, 8'h01, 4'b0001, 8'hE1, 1'b1, 1'b0};
        vt[8]  = '{4'b1111, 1'b0, 8'h01, 4'b0010, 8'hC8, 1'b1, 1'b0};
        vt[9]  = '{4'b1111, 1'b0, 8'h01, 4'b0100, 8'h64, 1'b1, 1'b0};
        vt[10] = '{4'b1111, 1'b0, 8'h01, 4'b1000, 8'h32, 1'b1, 1'b0};
        vt[11] = '{4'b1111, 1'b0, 8'h01, 4'b0001, 8'h19, 1'b1, 1'b0};
        vt[12] = '{4'b0000, 1'b0, 8'h01, 4'b0000, 8'h00, 1'b0, 1'b0};
        vt[13] = '{4'b0001, 1'b0, 8'h01, 4'b0001, 8'hB4, 1'b1, 1'b0};
        // Reseed with requests pending: two empty cycles, then rotation resumes at 1.
        vt[14] = '{4'b0011, 1'b1, 8'h01, 4'b0000, 8'h00, 1'b0, 1'b1};
        vt[15] = '{4'b0011, 1'b0, 8'h01, 4'b0000, 8'h00, 1'b0, 1'b0};
        vt[16] = '{4'b0011, 1'b0, 8'h01, 4'b0010, 8'h01, 1'b1, 1'b0};
        vt[17] = '{4'b0011, 1'b0, 8'h01, 4'b0001, 8'hB8, 1'b1, 1'b0};
        // Zero seed selects all-ones; seed changes outside LOAD are ignored.
        vt[18] = '{4'b0000, 1'b1, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b1};
        vt[19] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0};
        vt[20] = '{4'b0001, 1'b0, 8'h5A, 4'b0001, 8'hFF, 1'b1, 1'b0};
        vt[21] = '{4'b0001, 1'b0, 8'h5A, 4'b0001, 8'hC7, 1'b1, 1'b0};

        e0_gnt[0] = 4'b0000; e0_rnd[0] = 8'h00;
        e0_gnt[1] = 4'b0001; e0_rnd[1] = 8'h01;
        e0_gnt[2] = 4'b0010; e0_rnd[2] = 8'hB8;
        e0_gnt[3] = 4'b0100; e0_rnd[3] = 8'h5C;
        e0_gnt[4] = 4'b1000; e0_rnd[4] = 8'h2E;
        e0_gnt[5] = 4'b0001; e0_rnd[5] = 8'h17;

        n_vec  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        seed   = 8'h01;
        reseed = 1'b0;
        req0   = 4'b0000;
        req4   = 4'b0000;

        // Reset state.
        #12;
        chk("reset_gnt0", 32'(gnt0), 32'h0);
        chk("reset_rnd0", 32'(rnd0), 32'h0);
        chk("reset_busy0", 32'(busy0), 32'h1);
        chk("reset_busy4", 32'(busy4), 32'h1);

        // Warm-up of 4 steps on the second instance; first instance idles in SERVE.
        @(negedge clk);
        rst_n = 1'b1;
        req4  = 4'b0001;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                chk("w0_busy_after_load", 32'(busy0), 32'h0);
                chk("w0_gnt_after_load", 32'(gnt0), 32'h0);
            end
            if (e <= 4) begin
                chk($sformatf("w4_busy_e%0d", e), 32'(busy4), 32'h1);
                chk($sformatf("w4_gnt_e%0d", e), 32'(gnt4), 32'h0);
            end else if (e == 5) begin
                chk("w4_busy_e5", 32'(busy4), 32'h0);
                chk("w4_gnt_e5", 32'(gnt4), 32'h0);
            end else if (e == 6) begin
                chk("w4_gnt_e6", 32'(gnt4), 32'h1);
                chk("w4_rnd_e6", 32'(rnd4), 32'h17);
            end else begin
                chk("w4_gnt_e7", 32'(gnt4), 32'h1);
                chk("w4_rnd_e7", 32'(rnd4), 32'hB3);
            end
        end
        @(negedge clk);
        req4 = 4'b0000;

        // Table-driven vectors on the WARMUP=0 instance.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            req0   = vt[i].req;
            reseed = vt[i].rs;
            seed   = vt[i].seed;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_gnt", i), 32'(gnt0), 32'(vt[i].gnt));
            chk($sformatf("vec%0d_busy", i), 32'(busy0), 32'(vt[i].busy));
            if (vt[i].chk_rnd)
                chk($sformatf("vec%0d_rnd", i), 32'(rnd0), 32'(vt[i].rnd));
        end

        // Asynchronous reset while a grant is showing.
        chk("pre_rst_gnt", 32'(gnt0), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt0", 32'(gnt0), 32'h0);
        chk("async_rst_rnd0", 32'(rnd0), 32'h0);
        chk("async_rst_busy0", 32'(busy0), 32'h1);
        chk("async_rst_busy4", 32'(busy4), 32'h1);

        // After release: sequence repeats and req[0] wins a full 1111 request.
        @(negedge clk);
        rst_n  = 1'b1;
        reseed = 1'b0;
        seed   = 8'h01;
        req0   = 4'b1111;
        req4   = 4'b1111;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_gnt0_e%0d", e), 32'(gnt0), 32'(e0_gnt[e]));
            if (e > 0)
                chk($sformatf("post_rst_rnd0_e%0d", e), 32'(rnd0), 32'(e0_rnd[e]));
            if (e < 5) begin
                chk($sformatf("post_rst_gnt4_e%0d", e), 32'(gnt4), 32'h0);
                chk($sformatf("post_rst_busy4_e%0d", e), 32'(busy4), (e < 4) ? 32'h1 : 32'h0);
            end else begin
                chk("post_rst_gnt4_e5", 32'(gnt4), 32'h1);
                chk("post_rst_rnd4_e5", 32'(rnd4), 32'h17);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
